// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB); outputs combinational from state+ins.
// Instructions take 2-5 cycles; FETCH and MEM stall on mem_ready=0 with requests held stable.
module multicycle_controller #(
  parameter int FUNC_W = 3,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       ins,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              mem_re,
  output logic              mem_we,
  output logic [1:0]        mem_width,
  output logic              ir_we,
  output logic              pc_we,
  output logic [1:0]        npc_sel,
  output logic              reg_we,
  output logic [1:0]        reg_dst,
  output logic [1:0]        wd_sel,
  output logic              alu_src_imm,
  output logic [1:0]        ext_op,
  output logic [FUNC_W-1:0] alu_func,
  output logic              illegal,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    OP_ADDU, OP_SUBU, OP_JR, OP_ORI, OP_LUI, OP_LW, OP_LH, OP_LB,
    OP_SW, OP_BEQ, OP_J, OP_JAL, OP_ILL
  } op_t;

  localparam logic [FUNC_W-1:0] FN_ADD = FUNC_W'(3'd0);
  localparam logic [FUNC_W-1:0] FN_SUB = FUNC_W'(3'd1);
  localparam logic [FUNC_W-1:0] FN_OR  = FUNC_W'(3'd2);
  localparam logic [FUNC_W-1:0] FN_CMP = FUNC_W'(3'd3);
  localparam logic [FUNC_W-1:0] FN_LUI = FUNC_W'(3'd5);

  state_t state_r;
  state_t state_n;
  op_t    op;
  logic   is_load;
  logic   retire;
  logic   unused_ins;

  assign unused_ins = ^ins[25:6];
  assign state      = state_r;

  always_comb begin
    op = OP_ILL;
    if (ins[31:26] == 6'b000000) begin
      case (ins[5:0])
        6'b100001: op = OP_ADDU;
        6'b100011: op = OP_SUBU;
        6'b001000: op = OP_JR;
        default:   op = OP_ILL;
      endcase
    end else begin
      case (ins[31:26])
        6'b001101: op = OP_ORI;
        6'b001111: op = OP_LUI;
        6'b100011: op = OP_LW;
        6'b100001: op = OP_LH;
        6'b100000: op = OP_LB;
        6'b101011: op = OP_SW;
        6'b000100: op = OP_BEQ;
        6'b000010: op = OP_J;
        6'b000011: op = OP_JAL;
        default:   op = OP_ILL;
      endcase
    end
  end

  assign is_load = (op == OP_LW) || (op == OP_LH) || (op == OP_LB);

  always_comb begin
    state_n     = state_r;
    retire      = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    mem_width   = 2'd0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    npc_sel     = 2'd0;
    reg_we      = 1'b0;
    reg_dst     = 2'd0;
    wd_sel      = 2'd0;
    alu_src_imm = 1'b0;
    ext_op      = 2'd0;
    alu_func    = FN_ADD;
    illegal     = 1'b0;

    case (state_r)
      FETCH: begin
        mem_re = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_n = DECODE;
        end
      end

      DECODE: begin
        case (op)
          OP_J: begin
            pc_we   = 1'b1;
            npc_sel = 2'd2;
            retire  = 1'b1;
            state_n = FETCH;
          end
          OP_JAL: begin
            pc_we   = 1'b1;
            npc_sel = 2'd2;
            reg_we  = 1'b1;
            reg_dst = 2'd2;
            wd_sel  = 2'd2;
            retire  = 1'b1;
            state_n = FETCH;
          end
          OP_JR: begin
            pc_we   = 1'b1;
            npc_sel = 2'd3;
            retire  = 1'b1;
            state_n = FETCH;
          end
          OP_ILL: begin
            illegal = 1'b1;
            retire  = 1'b1;
            state_n = FETCH;
          end
          default: state_n = EXEC;
        endcase
      end

      EXEC: begin
        case (op)
          OP_ADDU: begin
            alu_func = FN_ADD;
            state_n  = WB;
          end
          OP_SUBU: begin
            alu_func = FN_SUB;
            state_n  = WB;
          end
          OP_ORI: begin
            alu_src_imm = 1'b1;
            ext_op      = 2'd0;
            alu_func    = FN_OR;
            state_n     = WB;
          end
          OP_LUI: begin
            alu_src_imm = 1'b1;
            ext_op      = 2'd2;
            alu_func    = FN_LUI;
            state_n     = WB;
          end
          OP_LW, OP_LH, OP_LB, OP_SW: begin
            alu_src_imm = 1'b1;
            ext_op      = 2'd1;
            alu_func    = FN_ADD;
            state_n     = MEM;
          end
          OP_BEQ: begin
            alu_func = FN_CMP;
            npc_sel  = 2'd1;
            pc_we    = zero;
            retire   = 1'b1;
            state_n  = FETCH;
          end
          default: state_n = FETCH;
        endcase
      end

      MEM: begin
        // Width depends only on the held instruction, so it stays stable across stalls.
        if (op == OP_LH)      mem_width = 2'd1;
        else if (op == OP_LB) mem_width = 2'd2;
        if (is_load) begin
          mem_re = 1'b1;
          if (mem_ready) state_n = WB;
        end else if (op == OP_SW) begin
          mem_we = 1'b1;
          if (mem_ready) begin
            retire  = 1'b1;
            state_n = FETCH;
          end
        end else begin
          state_n = FETCH;
        end
      end

      WB: begin
        reg_we = 1'b1;
        if (op == OP_ADDU || op == OP_SUBU) reg_dst = 2'd1;
        if (is_load) wd_sel = 2'd1;
        retire  = 1'b1;
        state_n = FETCH;
      end

      default: state_n = FETCH;
    endcase

    if (reset) begin
      mem_re  = 1'b0;
      mem_we  = 1'b0;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      reg_we  = 1'b0;
      illegal = 1'b0;
      retire  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FETCH;
      retired <= '0;
    end else begin
      state_r <= state_n;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomised bench: per-cycle expected outputs derived from instruction-level rules go into a
// scoreboard queue; a negedge monitor pops and compares against the DUT (plus a 4-bit-counter copy).
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ins;
  logic        zero;
  logic        mem_ready;

  logic        mem_re, mem_we, ir_we, pc_we, reg_we, alu_src_imm, illegal;
  logic [1:0]  mem_width, npc_sel, reg_dst, wd_sel, ext_op;
  logic [2:0]  alu_func, state;
  logic [31:0] retired;

  logic        s_mem_re, s_mem_we, s_ir_we, s_pc_we, s_reg_we, s_alu_src_imm, s_illegal;
  logic [1:0]  s_mem_width, s_npc_sel, s_reg_dst, s_wd_sel, s_ext_op;
  logic [2:0]  s_alu_func, s_state;
  logic [3:0]  s_retired;

  always #5 clk = ~clk;

  multicycle_controller #(.FUNC_W(3), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .ins(ins), .zero(zero), .mem_ready(mem_ready),
    .mem_re(mem_re), .mem_we(mem_we), .mem_width(mem_width), .ir_we(ir_we), .pc_we(pc_we),
    .npc_sel(npc_sel), .reg_we(reg_we), .reg_dst(reg_dst), .wd_sel(wd_sel),
    .alu_src_imm(alu_src_imm), .ext_op(ext_op), .alu_func(alu_func), .illegal(illegal),
    .state(state), .retired(retired)
  );

  multicycle_controller #(.FUNC_W(3), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .ins(ins), .zero(zero), .mem_ready(mem_ready),
    .mem_re(s_mem_re), .mem_we(s_mem_we), .mem_width(s_mem_width), .ir_we(s_ir_we),
    .pc_we(s_pc_we), .npc_sel(s_npc_sel), .reg_we(s_reg_we), .reg_dst(s_reg_dst),
    .wd_sel(s_wd_sel), .alu_src_imm(s_alu_src_imm), .ext_op(s_ext_op), .alu_func(s_alu_func),
    .illegal(s_illegal), .state(s_state), .retired(s_retired)
  );

  typedef struct packed {
    logic [2:0]  state;
    logic        mem_re;
    logic        mem_we;
    logic [1:0]  mem_width;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  npc_sel;
    logic        reg_we;
    logic [1:0]  reg_dst;
    logic [1:0]  wd_sel;
    logic        alu_src_imm;
    logic [1:0]  ext_op;
    logic [2:0]  alu_func;
    logic        illegal;
    logic [31:0] retired;
    logic [3:0]  retired4;
  } obs_t;

  typedef enum int {
    C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_LW, C_LH, C_LB, C_SW, C_BEQ, C_J, C_JAL, C_ILL
  } icls_t;

  obs_t        sb[$];
  obs_t        got, want;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] model_ret = 0;

  always @(negedge clk) begin
    cyc++;
    if (sb.size() > 0) begin
      want = sb.pop_front();
      got.state = state;          got.mem_re = mem_re;      got.mem_we = mem_we;
      got.mem_width = mem_width;  got.ir_we = ir_we;        got.pc_we = pc_we;
      got.npc_sel = npc_sel;      got.reg_we = reg_we;      got.reg_dst = reg_dst;
      got.wd_sel = wd_sel;        got.alu_src_imm = alu_src_imm;
      got.ext_op = ext_op;        got.alu_func = alu_func;  got.illegal = illegal;
      got.retired = retired;      got.retired4 = s_retired;
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL outputs cyc=%0d ins=%h: got state=%0d ret=%0d ret4=%0d vec=%h, expected state=%0d ret=%0d ret4=%0d vec=%h",
                 cyc, ins, got.state, got.retired, got.retired4, got, want.state, want.retired,
                 want.retired4, want);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  function automatic obs_t blank(input logic [2:0] st);
    obs_t e;
    e = '0;
    e.state    = st;
    e.retired  = model_ret;
    e.retired4 = model_ret[3:0];
    return e;
  endfunction

  // Drive this cycle's inputs, record what the outputs must be, then advance one clock.
  task automatic step(input logic rst, input logic rdy, input logic z, input obs_t e);
    reset     = rst;
    mem_ready = rdy;
    zero      = z;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] gen(input icls_t c);
    logic [31:0] r;
    logic [5:0]  opc;
    logic [5:0]  fn;
    r = $urandom;
    case (c)
      C_ADDU: return {6'd0, r[25:6], 6'h21};
      C_SUBU: return {6'd0, r[25:6], 6'h23};
      C_JR:   return {6'd0, r[25:6], 6'h08};
      C_ORI:  return {6'h0D, r[25:0]};
      C_LUI:  return {6'h0F, r[25:0]};
      C_LW:   return {6'h23, r[25:0]};
      C_LH:   return {6'h21, r[25:0]};
      C_LB:   return {6'h20, r[25:0]};
      C_SW:   return {6'h2B, r[25:0]};
      C_BEQ:  return {6'h04, r[25:0]};
      C_J:    return {6'h02, r[25:0]};
      C_JAL:  return {6'h03, r[25:0]};
      default: begin
        if (r[31]) begin
          fn = 6'($urandom_range(0, 63));
          while (fn == 6'h21 || fn == 6'h23 || fn == 6'h08) fn = 6'($urandom_range(0, 63));
          return {6'd0, r[25:6], fn};
        end
        opc = 6'($urandom_range(1, 63));
        while (opc inside {6'h0D, 6'h0F, 6'h23, 6'h21, 6'h20, 6'h2B, 6'h04, 6'h02, 6'h03})
          opc = 6'($urandom_range(1, 63));
        return {opc, r[25:0]};
      end
    endcase
  endfunction

  // One whole instruction: fst/mst = stall cycles in FETCH/MEM (negative = random);
  // abort asserts reset after the MEM stalls instead of completing.
  task automatic run_instr(input logic [31:0] iw, input icls_t c, input logic z,
                           input int fst, input int mst, input bit abort);
    obs_t e;
    int   fs, ms;
    bit   ld, mem_op;
    fs     = (fst < 0) ? int'($urandom_range(0, 3)) : fst;
    ms     = (mst < 0) ? int'($urandom_range(0, 3)) : mst;
    ld     = (c == C_LW) || (c == C_LH) || (c == C_LB);
    mem_op = ld || (c == C_SW);
    ins    = iw;

    for (int k = 0; k <= fs; k++) begin
      e = blank(3'd0);
      e.mem_re = 1'b1;
      if (k == fs) begin
        e.ir_we = 1'b1;
        e.pc_we = 1'b1;
      end
      step(1'b0, k == fs, 1'($urandom), e);
    end

    e = blank(3'd1);
    if (c == C_J || c == C_JAL || c == C_JR || c == C_ILL) begin
      if (c == C_ILL) e.illegal = 1'b1;
      else begin
        e.pc_we   = 1'b1;
        e.npc_sel = (c == C_JR) ? 2'd3 : 2'd2;
      end
      if (c == C_JAL) begin
        e.reg_we  = 1'b1;
        e.reg_dst = 2'd2;
        e.wd_sel  = 2'd2;
      end
      step(1'b0, 1'($urandom), 1'($urandom), e);
      model_ret++;
      return;
    end
    step(1'b0, 1'($urandom), 1'($urandom), e);

    e = blank(3'd2);
    case (c)
      C_SUBU: e.alu_func = 3'd1;
      C_ORI:  begin e.alu_src_imm = 1'b1; e.alu_func = 3'd2; end
      C_LUI:  begin e.alu_src_imm = 1'b1; e.ext_op = 2'd2; e.alu_func = 3'd5; end
      C_BEQ:  begin e.alu_func = 3'd3; e.npc_sel = 2'd1; e.pc_we = z; end
      default: if (mem_op) begin e.alu_src_imm = 1'b1; e.ext_op = 2'd1; end
    endcase
    step(1'b0, 1'($urandom), (c == C_BEQ) ? z : 1'($urandom), e);
    if (c == C_BEQ) begin
      model_ret++;
      return;
    end

    if (mem_op) begin
      for (int k = 0; k <= ms; k++) begin
        e = blank(3'd3);
        e.mem_width = (c == C_LH) ? 2'd1 : (c == C_LB) ? 2'd2 : 2'd0;
        if (abort && k == ms) begin
          step(1'b1, 1'($urandom), 1'($urandom), e);
          model_ret = 0;
          return;
        end
        e.mem_re = ld;
        e.mem_we = !ld;
        step(1'b0, k == ms, 1'($urandom), e);
      end
      if (!ld) begin
        model_ret++;
        return;
      end
    end

    e = blank(3'd4);
    e.reg_we  = 1'b1;
    e.reg_dst = (c == C_ADDU || c == C_SUBU) ? 2'd1 : 2'd0;
    e.wd_sel  = ld ? 2'd1 : 2'd0;
    step(1'b0, 1'($urandom), 1'($urandom), e);
    model_ret++;
  endtask

  initial begin
    obs_t  e;
    icls_t c;
    reset     = 1'b1;
    ins       = 32'd0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    model_ret = 0;
    e = blank(3'd0);
    step(1'b1, 1'b1, 1'b0, e);

    run_instr(32'h00221821, C_ADDU, 1'b0, 0, 0, 1'b0);
    run_instr(32'h8C220004, C_LW,   1'b0, 0, 3, 1'b0);
    run_instr(32'h10220003, C_BEQ,  1'b1, 0, 0, 1'b0);
    run_instr(32'h10220003, C_BEQ,  1'b0, 0, 0, 1'b0);
    run_instr(32'h0C000010, C_JAL,  1'b0, 0, 0, 1'b0);
    run_instr(32'hFC000000, C_ILL,  1'b0, 2, 0, 1'b0);
    run_instr(gen(C_SW),    C_SW,   1'b0, 0, 2, 1'b1);
    run_instr(gen(C_LH),    C_LH,   1'b0, 1, 1, 1'b0);
    run_instr(gen(C_LB),    C_LB,   1'b0, 0, 2, 1'b0);
    run_instr(gen(C_ILL),   C_ILL,  1'b0, 0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      c = icls_t'($urandom_range(0, 12));
      run_instr(gen(c), c, 1'($urandom), -1, -1, 1'b0);
    end

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
